clk_rst_sequencer: RTL and testbench
====================================

# clk_rst_sequencer

Reset sequencer that sits directly downstream of the board PLL clock generator. It drives the PLL reset, watches the PLL lock indication, and releases the DDR3 controller reset only after lock has been continuously stable. It also handles loss of lock and lock timeouts with bounded retries. It runs on the free-running board input clock, the same clock that feeds the PLL, so it keeps operating while the PLL outputs are stopped.

## Interface
Parameters:
- PLL_RST_CYCLES, default 16: number of cycles `o_pll_reset` is held high per PLL reset attempt (≥1).
- LOCK_TIMEOUT, default 65536: maximum number of cycles to wait for lock after PLL reset release (≥2).
- STABLE_CYCLES, default 1024: number of consecutive locked cycles required before the controller reset is released (≥1).
- MAX_RETRIES, default 3: number of PLL reset retries after a timeout before the block declares failure (0–15).

Ports:
- `i_clk`, in, 1: free-running board clock (200 MHz). This is the only clock.
- `i_rst_n`, in, 1: asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronous to `i_clk`, provided by board reset logic.
- `i_pll_locked`, in, 1: PLL lock flag. Asynchronous to `i_clk`; synchronized internally.
- `o_pll_reset`, out, 1: active-high PLL reset.
- `o_ctrl_rst_n`, out, 1: active-low reset for the DDR3 controller and PHY domains.
- `o_ready`, out, 1: high while the block is in RUN.
- `o_lock_lost`, out, 1: one-cycle pulse when lock drops while in RUN.
- `o_retry_count`, out, 4: number of timeout retries consumed since the last successful RUN.
- `o_error`, out, 1: sticky flag meaning the retry budget is exhausted.

## Operation
- `i_pll_locked` passes through a 2-flop synchronizer; its output is `locked_s`. All decisions use `locked_s`.
- There is one shared cycle counter `cnt`. It is cleared on every state transition.
- The state machine is Moore. All outputs are registered and decoded from the state register.
- PLL_RST: `o_pll_reset`=1. When `cnt`==PLL_RST_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK: `o_pll_reset`=0.
  - If `locked_s`=1, go to STABLE.
  - Otherwise, when `cnt`==LOCK_TIMEOUT-1: if `o_retry_count`==MAX_RETRIES, go to FAIL; else increment `o_retry_count` and go to PLL_RST.
- STABLE: `cnt` counts consecutive cycles with `locked_s` high.
  - If `locked_s`=0, go to WAIT_LOCK. The timeout window restarts from 0.
  - When `cnt`==STABLE_CYCLES-1 and `locked_s`=1, go to RUN.
- RUN: `o_ctrl_rst_n`=1 and `o_ready`=1. If `locked_s`=0, go to PLL_RST, pulse `o_lock_lost` for one cycle, and clear `o_retry_count` to 0.
- FAIL: `o_pll_reset`=1, `o_ctrl_rst_n`=0, `o_error`=1. FAIL is terminal; only `i_rst_n` exits it.
- `o_ctrl_rst_n` is 0 in every state except RUN.
- `i_rst_n` asserted in any state returns the block to PLL_RST immediately. A reset mid-operation therefore re-asserts the PLL reset and the controller reset asynchronously.

## Timing
- Reset values: state=PLL_RST, `o_pll_reset`=1, `o_ctrl_rst_n`=0, `o_ready`=0, `o_lock_lost`=0, `o_retry_count`=0, `o_error`=0, synchronizer flops=0, `cnt`=0.
- Edge numbering below counts the first `i_clk` edge after `i_rst_n` deassertion as edge 1.
  - `o_pll_reset` falls on edge PLL_RST_CYCLES.
- Lock-to-release latency: count the first edge that samples `i_pll_locked`=1 during WAIT_LOCK as edge 1.
  - `o_ctrl_rst_n` and `o_ready` rise on edge STABLE_CYCLES+3, provided lock stays high throughout.
- Loss of lock in RUN: `o_ctrl_rst_n` falls and `o_lock_lost` pulses 3 edges after `i_pll_locked` falls (2 synchronizer edges plus 1 state edge).
- Timeout: `o_pll_reset` rises on edge LOCK_TIMEOUT of WAIT_LOCK, counting the WAIT_LOCK entry edge as edge 0.
- Simultaneous events: in WAIT_LOCK, if `locked_s`=1 on the timeout cycle, lock wins and the block goes to STABLE.
- Counter width is $clog2 of the largest of PLL_RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES. The counter never wraps because it is cleared on every transition.

## Structure
- Shared package `clk_rst_pkg` holds:
  - the state encodings: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4 (3-bit);
  - a width helper function for the counter.
- Sub-module `sync_2ff`: a 1-bit two-flop synchronizer with asynchronous active-low clear. It is instantiated once, for `i_pll_locked`.

## Test plan
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- Clean bring-up: release reset, raise `i_pll_locked` 10 cycles later -> `o_pll_reset` falls on edge 4; `o_ctrl_rst_n`/`o_ready` rise exactly 11 edges after lock is first sampled; `o_retry_count`=0.
- Lock glitch: drop lock for 1 cycle at STABLE cycle 5 -> no release; STABLE restarts; release occurs 11 edges after lock is sampled high again.
- Timeout with recovery: hold lock low for 2 windows, then raise it -> `o_pll_reset` re-pulses 4 cycles twice; `o_retry_count`=2; RUN is reached; a later loss of lock clears the count to 0.
- Exhausted retries: never assert lock -> 3 waits of 20 cycles each; FAIL entered with `o_error`=1, `o_pll_reset`=1, `o_ctrl_rst_n`=0, held for 1000 cycles.
- Loss of lock in RUN: drop lock -> `o_lock_lost` pulses for one cycle 3 edges later; `o_ctrl_rst_n`=0 on the same edge; `o_pll_reset` is high for 4 cycles.
- Asynchronous reset mid-STABLE: assert `i_rst_n`=0 between clock edges -> all outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/clk_rst_pkg.sv
// Shared definitions for the board clock/reset sequencer.
package clk_rst_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-low clear.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_rst_sequencer.sv
// PLL reset / lock supervisor that gates the DDR3 controller reset.
import clk_rst_pkg::*;

module clk_rst_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pll_locked,
    output logic       o_pll_reset,
    output logic       o_ctrl_rst_n,
    output logic       o_ready,
    output logic       o_lock_lost,
    output logic [3:0] o_retry_count,
    output logic       o_error
);

    localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [3:0]    retry_q;
    logic          locked_s;

    logic pll_reset_d;
    logic ctrl_rst_n_d;
    logic ready_d;
    logic lock_lost_d;
    logic error_d;

    sync_2ff u_lock_sync (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .d     (i_pll_locked),
        .q     (locked_s)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= PLL_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = (retry_q == RETRY_MAX) ? FAIL : PLL_RST;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STB_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!locked_s) state_d = PLL_RST;
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = PLL_RST;
            end
        endcase
    end

    // Counter is frozen in RUN/FAIL so it can never wrap while parked there.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            if (state_d != state_q || state_q == RUN || state_q == FAIL) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == WAIT_LOCK && state_d == PLL_RST) begin
                retry_q <= retry_q + 4'd1;
            end else if (state_q == RUN && state_d == PLL_RST) begin
                retry_q <= '0;
            end
        end
    end

    always_comb begin
        pll_reset_d  = 1'b0;
        ctrl_rst_n_d = 1'b0;
        ready_d      = 1'b0;
        error_d      = 1'b0;
        lock_lost_d  = (state_q == RUN) && (state_d == PLL_RST);
        unique case (1'b1)
            (state_d == RUN): begin
                ctrl_rst_n_d = 1'b1;
                ready_d      = 1'b1;
            end
            (state_d == FAIL): begin
                pll_reset_d = 1'b1;
                error_d     = 1'b1;
            end
            (state_d == PLL_RST): begin
                pll_reset_d = 1'b1;
            end
            default: begin
                pll_reset_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pll_reset  <= 1'b1;
            o_ctrl_rst_n <= 1'b0;
            o_ready      <= 1'b0;
            o_lock_lost  <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            o_pll_reset  <= pll_reset_d;
            o_ctrl_rst_n <= ctrl_rst_n_d;
            o_ready      <= ready_d;
            o_lock_lost  <= lock_lost_d;
            o_error      <= error_d;
        end
    end

    assign o_retry_count = retry_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Directed bench for clk_rst_sequencer with short timing parameters.
module tb_clk_rst_sequencer;

    logic       clk;
    logic       rst_n;
    logic       lock;
    logic       pll_reset;
    logic       ctrl_rst_n;
    logic       ready;
    logic       lock_lost;
    logic [3:0] retry;
    logic       error;

    int checks = 0;
    int errors = 0;

    clk_rst_sequencer #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8),
        .MAX_RETRIES    (2)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pll_locked  (lock),
        .o_pll_reset   (pll_reset),
        .o_ctrl_rst_n  (ctrl_rst_n),
        .o_ready       (ready),
        .o_lock_lost   (lock_lost),
        .o_retry_count (retry),
        .o_error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pll"}, 32'(pll_reset), 1);
        check({tag, "_ctrl"}, 32'(ctrl_rst_n), 0);
        check({tag, "_ready"}, 32'(ready), 0);
        check({tag, "_lost"}, 32'(lock_lost), 0);
        check({tag, "_retry"}, 32'(retry), 0);
        check({tag, "_err"}, 32'(error), 0);
    endtask

    initial begin
        rst_n = 1'b1;
        lock  = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_reset_vals("por");

        // clean bring-up
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        check("pll_hi_e3", 32'(pll_reset), 1);
        step(1);
        check("pll_lo_e4", 32'(pll_reset), 0);
        step(6);
        lock = 1'b1;
        step(10);
        check("bu_ready_l10", 32'(ready), 0);
        check("bu_ctrl_l10", 32'(ctrl_rst_n), 0);
        step(1);
        check("bu_ready_l11", 32'(ready), 1);
        check("bu_ctrl_l11", 32'(ctrl_rst_n), 1);
        check("bu_retry", 32'(retry), 0);

        // loss of lock in RUN
        step(5);
        lock = 1'b0;
        step(2);
        check("ll_lost_e2", 32'(lock_lost), 0);
        check("ll_ctrl_e2", 32'(ctrl_rst_n), 1);
        step(1);
        check("ll_lost_e3", 32'(lock_lost), 1);
        check("ll_ctrl_e3", 32'(ctrl_rst_n), 0);
        check("ll_pll_e3", 32'(pll_reset), 1);
        check("ll_ready_e3", 32'(ready), 0);
        step(1);
        check("ll_lost_e4", 32'(lock_lost), 0);
        step(2);
        check("ll_pll_e6", 32'(pll_reset), 1);
        step(1);
        check("ll_pll_e7", 32'(pll_reset), 0);
        lock = 1'b1;

        // one-cycle glitch during STABLE
        step(3);
        step(3);
        lock = 1'b0;
        step(1);
        lock = 1'b1;
        step(4);
        check("gl_no_release", 32'(ready), 0);
        step(6);
        check("gl_ready_l10", 32'(ready), 0);
        step(1);
        check("gl_ready_l11", 32'(ready), 1);
        check("gl_ctrl_l11", 32'(ctrl_rst_n), 1);

        // two timeouts then recovery
        step(3);
        lock = 1'b0;
        step(3);
        check("to_lost", 32'(lock_lost), 1);
        check("to_pll_start", 32'(pll_reset), 1);
        step(4);
        check("to_w1_pll", 32'(pll_reset), 0);
        step(19);
        check("to_w1_e19_pll", 32'(pll_reset), 0);
        check("to_w1_e19_retry", 32'(retry), 0);
        step(1);
        check("to_w1_e20_pll", 32'(pll_reset), 1);
        check("to_w1_e20_retry", 32'(retry), 1);
        step(3);
        check("to_rp1_pll", 32'(pll_reset), 1);
        step(1);
        check("to_w2_pll", 32'(pll_reset), 0);
        step(20);
        check("to_w2_e20_pll", 32'(pll_reset), 1);
        check("to_w2_e20_retry", 32'(retry), 2);
        step(4);
        check("to_w3_pll", 32'(pll_reset), 0);
        lock = 1'b1;
        step(10);
        check("to_ready_l10", 32'(ready), 0);
        step(1);
        check("to_ready_l11", 32'(ready), 1);
        check("to_retry_run", 32'(retry), 2);
        step(2);
        lock = 1'b0;
        step(3);
        check("to_lost2", 32'(lock_lost), 1);
        check("to_retry_clr", 32'(retry), 0);

        // retries exhausted
        step(4);
        check("ex_w1_pll", 32'(pll_reset), 0);
        step(67);
        check("ex_pre_err", 32'(error), 0);
        check("ex_pre_pll", 32'(pll_reset), 0);
        step(1);
        check("ex_err", 32'(error), 1);
        check("ex_pll", 32'(pll_reset), 1);
        check("ex_ctrl", 32'(ctrl_rst_n), 0);
        check("ex_ready", 32'(ready), 0);
        check("ex_retry", 32'(retry), 2);
        step(500);
        lock = 1'b1;
        step(500);
        check("ex_hold_err", 32'(error), 1);
        check("ex_hold_pll", 32'(pll_reset), 1);
        check("ex_hold_ctrl", 32'(ctrl_rst_n), 0);
        check("ex_hold_ready", 32'(ready), 0);

        // asynchronous reset out of FAIL
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("rst_fail");
        lock = 1'b0;

        // asynchronous reset mid-STABLE
        @(negedge clk);
        rst_n = 1'b1;
        step(4);
        check("st_pll_e4", 32'(pll_reset), 0);
        lock = 1'b1;
        step(6);
        check("st_pll_pre", 32'(pll_reset), 0);
        check("st_ready_pre", 32'(ready), 0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("rst_stable");
        step(3);
        check("st_hold_pll", 32'(pll_reset), 1);
        check("st_hold_ctrl", 32'(ctrl_rst_n), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
